iter_integer_linear_inverse: RTL
================================

Name: iter_integer_linear_inverse

Overview:
- Iterative solver for x = (y - b) / m on unsigned integers.
- It is the inverse of iter_integer_linear_calc, which computes y = m*x + b, and uses the same wr/valid strobe style.
- Uses a restoring divider that resolves one quotient bit per clock.
- Sits beside the forward calculator in calibration paths to turn a measured y back into a calibrated x.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- wr  input  1  start strobe; sampled only when busy=0.
- y  input  WIDTH  measured value.
- m  input  WIDTH  slope (divisor).
- b  input  WIDTH  offset.
- x  output  WIDTH  quotient result; registered.
- rem  output  WIDTH  remainder of (y-b)/m; registered.
- valid  output  1  one-cycle pulse when x, rem and the flags are updated.
- busy  output  1  high from the edge that accepts wr until valid is registered.
- div_by_zero  output  1  result flag: m was 0.
- underflow  output  1  result flag: y < b.

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. rst has priority over wr.
- rst asserted mid-operation aborts the computation with no valid pulse.
- State IDLE:
  - wr=1 at an edge E0 latches y, m and b.
  - Sets busy=1 and moves to SUB.
- State SUB (edge E1):
  - diff = y - b.
  - If y < b: x=0, rem=0, underflow=1, div_by_zero=0, valid=1, go to IDLE.
  - Else if m == 0: x = all ones, rem = diff, div_by_zero=1, underflow=0, valid=1, go to IDLE.
  - Else: clear the partial remainder, load diff into the shift register, cnt=0, go to DIV.
  - underflow is checked before div_by_zero, so it wins when both apply.
- State DIV (edges E2..E33):
  - Each edge: shift the next dividend MSB into the partial remainder P (WIDTH+1 bits).
  - Compute trial = P - m. If trial >= 0, keep trial and shift in quotient bit 1; otherwise keep P and shift in 0.
  - cnt increments each step; the step with cnt = WIDTH-1 is the last.
  - On the last step (E33 for WIDTH=32): x and rem are registered, both flags clear, valid=1, busy=0, go to IDLE.
- Latency:
  - Normal case: WIDTH+1 edges after E0.
  - Error cases: 1 edge after E0.
- valid is high for exactly one cycle. x, rem and the flags hold until the next result or rst.
- wr while busy=1 is ignored (not queued). wr arriving in the same cycle valid is registered is also ignored; a new wr is accepted from the following edge.
- Width rules:
  - The subtraction is WIDTH+1 bits wide; its borrow is the underflow detect.
  - The quotient fits in WIDTH bits, since diff < 2^WIDTH and m >= 1.

Optional Feature:
- Macro: ITER_LINEAR_INVERSE_ROUND_EN.
- Defined:
  - On the final DIV step, if 2*rem >= m then x = quotient+1, saturating at all ones.
  - rem is still reported as the truncated remainder. Latency is unchanged.
- Undefined: x is the truncated quotient.

Decomposition:
- Package iilc_pkg holds:
  - The state enum {IDLE, SUB, DIV}.
  - The default WIDTH.
  - The counter width, $clog2(WIDTH).
  - The all-ones localparam used for the div-by-zero result.
- One natural sub-module, iter_udiv:
  - Contains the restoring-division datapath: start/done handshake, dividend, divisor, quotient, remainder.
  - The top-level block keeps the SUB/error logic, rounding, and output registers.

Test Plan:
- Basic: b=10, y=186, m=11, wr pulse → 33 cycles later valid=1 for 1 cycle with x=16, rem=0, flags 0, busy low.
- Remainder: b=10, y=100, m=7 → x=12, rem=6. With ITER_LINEAR_INVERSE_ROUND_EN defined, x=13 and rem=6.
- Errors:
  - y=5, b=10, m=3 → valid at 1 cycle latency, x=0, underflow=1.
  - y=50, b=10, m=0 → x=0xFFFFFFFF, rem=40, div_by_zero=1.
- Busy rule: start y=94, b=10, m=7; pulse wr with y=186, m=11 at cycle 10 → that wr is ignored. Only one valid pulse, with x=12, rem=0.
- Reset mid-op: start y=186, b=10, m=11; assert rst at cycle 15 for 1 cycle → no valid, all outputs 0. A following wr with the same inputs yields x=16.
- Extremes: y=0xFFFFFFFF, b=0, m=1 → x=0xFFFFFFFF, rem=0. Then y=0xFFFFFFFF, b=0, m=2 → x=0x7FFFFFFF, rem=1; with rounding x=0x80000000.

Source files
------------

// File: rtl/iilc_pkg.sv
// Shared types and constants for the iterative linear-inverse solver x = (y - b) / m.
package iilc_pkg;

  typedef enum logic [1:0] {IDLE, SUB, DIV} state_e;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W = $clog2(WIDTH_DEF);
  localparam logic [WIDTH_DEF-1:0] ALL_ONES = '1;

endpackage

// File: rtl/iter_udiv.sv
// Restoring unsigned divider, one quotient bit per clock. Quotient bits are shifted
// into the vacated LSBs of the dividend register; done/quo/rem show the final step's results.
module iter_udiv #(
  parameter int WIDTH = 32,
  parameter int CW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH-1:0] p_sub;
  logic             qbit;

  always_comb begin
    p_sh  = {p_q, dvd_q[WIDTH-1]};
    qbit  = (p_sh >= {1'b0, dsr_q});
    // When the trial succeeds the result is below the divisor, so the low WIDTH bits suffice.
    p_sub = p_sh[WIDTH-1:0] - dsr_q;
    p_d   = qbit ? p_sub : p_sh[WIDTH-1:0];
    dvd_d = {dvd_q[WIDTH-2:0], qbit};
  end

  assign done_o = run_q && (cnt_q == CW'(WIDTH - 1));
  assign quo_o  = dvd_d;
  assign rem_o  = p_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q   <= '0;
      dvd_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      p_q   <= '0;
      dvd_q <= dividend_i;
      dsr_q <= divisor_i;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      p_q   <= p_d;
      dvd_q <= dvd_d;
      cnt_q <= cnt_q + CW'(1);
      if (done_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/iter_integer_linear_inverse.sv
// Iterative solver x = (y - b) / m with underflow and divide-by-zero flags.
// Optional round-to-nearest of x under ITER_LINEAR_INVERSE_ROUND_EN.
module iter_integer_linear_inverse
  import iilc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] rem,
  output logic             valid,
  output logic             busy,
  output logic             div_by_zero,
  output logic             underflow
);

  localparam int CW = (WIDTH == WIDTH_DEF) ? CNT_W : $clog2(WIDTH);
  localparam logic [WIDTH-1:0] X_SAT = (WIDTH == WIDTH_DEF) ? WIDTH'(ALL_ONES) : '1;

  state_e           state_q;
  logic [WIDTH-1:0] y_q, m_q, b_q;
  logic [WIDTH-1:0] x_q, rem_q;
  logic             valid_q, busy_q, dbz_q, unf_q;

  logic [WIDTH:0]   diff_d;
  logic             start_d;
  logic             div_done;
  logic [WIDTH-1:0] div_quo, div_rem, x_d;

  // Bit WIDTH is the borrow, i.e. y < b.
  assign diff_d  = {1'b0, y_q} - {1'b0, b_q};
  assign start_d = (state_q == SUB) && !diff_d[WIDTH] && (m_q != '0);

  iter_udiv #(.WIDTH(WIDTH), .CW(CW)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_d),
    .dividend_i (diff_d[WIDTH-1:0]),
    .divisor_i  (m_q),
    .done_o     (div_done),
    .quo_o      (div_quo),
    .rem_o      (div_rem)
  );

`ifdef ITER_LINEAR_INVERSE_ROUND_EN
  always_comb begin
    x_d = div_quo;
    if ({div_rem, 1'b0} >= {1'b0, m_q} && div_quo != X_SAT) x_d = div_quo + WIDTH'(1);
  end
`else
  assign x_d = div_quo;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      m_q     <= '0;
      b_q     <= '0;
      x_q     <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr) begin
            y_q     <= y;
            m_q     <= m;
            b_q     <= b;
            busy_q  <= 1'b1;
            state_q <= SUB;
          end
        end
        SUB: begin
          if (diff_d[WIDTH]) begin
            x_q     <= '0;
            rem_q   <= '0;
            unf_q   <= 1'b1;
            dbz_q   <= 1'b0;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (m_q == '0) begin
            x_q     <= X_SAT;
            rem_q   <= diff_d[WIDTH-1:0];
            unf_q   <= 1'b0;
            dbz_q   <= 1'b1;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= DIV;
          end
        end
        DIV: begin
          if (div_done) begin
            x_q     <= x_d;
            rem_q   <= div_rem;
            unf_q   <= 1'b0;
            dbz_q   <= 1'b0;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x           = x_q;
  assign rem         = rem_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;
  assign underflow   = unf_q;

endmodule
